// File: rtl/nibble_packer_pkg.sv
// Shared widths, FSM state encoding and parity helper for the nibble packer.
// NIBBLE_PACKER_PARITY_EN enables the per-word parity output.
package nibble_packer_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 32;
  localparam int NIBBLES_PER_WORD = 8;
  localparam int LEN_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PUSH = 2'd2
  } state_e;

  function automatic logic word_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble input / packed word output bundle; master = producer/consumer side, slave = packer.
// NIBBLE_PACKER_PARITY_EN adds the word_parity signal.
interface nibble_packer_if;
  import nibble_packer_pkg::*;

  logic [NIBBLE_W-1:0] nibble_in;
  logic                nibble_valid;
  logic                nibble_ready;
  logic                flush;
  logic [WORD_W-1:0]   word_out;
  logic [LEN_W-1:0]    word_len;
  logic                word_valid;
  logic                word_ready;
  logic                fifo_full;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic                word_parity;
`endif

  modport master (
    output nibble_in, nibble_valid, flush, word_ready,
    input  nibble_ready, word_out, word_len, word_valid, fifo_full
`ifdef NIBBLE_PACKER_PARITY_EN
    , input word_parity
`endif
  );

  modport slave (
    input  nibble_in, nibble_valid, flush, word_ready,
    output nibble_ready, word_out, word_len, word_valid, fifo_full
`ifdef NIBBLE_PACKER_PARITY_EN
    , output word_parity
`endif
  );

endinterface

// File: rtl/nibble_fifo.sv
// Synchronous FIFO for packed word entries; head output reads as zero while empty.
// A push while full is accepted only together with a pop in the same cycle.
module nibble_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/nibble_packer.sv
// Packs MSB-first nibbles into 32-bit words and queues them in an output FIFO.
// NIBBLE_PACKER_PARITY_EN adds a stored per-word parity bit on word_parity.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  nibble_packer_if.slave bus
);

`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int ENTRY_W = LEN_W + WORD_W + 1;
`else
  localparam int ENTRY_W = LEN_W + WORD_W;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [LEN_W-1:0]  cnt_nx;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  assign bus.nibble_ready = (state_q != ST_PUSH);
  assign accept           = bus.nibble_valid && bus.nibble_ready;
  assign cnt_nx           = cnt_q + LEN_W'(accept);
  assign fifo_pop         = bus.word_ready && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    fifo_push = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          pack_d = pack_q | ({bus.nibble_in, {(WORD_W-NIBBLE_W){1'b0}}} >> {cnt_q, 2'b00});
          cnt_d  = cnt_nx;
        end
        if ((cnt_nx == LEN_W'(NIBBLES_PER_WORD)) || (bus.flush && (cnt_nx != '0))) begin
          state_d = ST_PUSH;
        end else if (cnt_nx != '0) begin
          state_d = ST_FILL;
        end
      end
      ST_PUSH: begin
        // A full FIFO still takes the word when the head leaves this cycle.
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pack_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign fifo_din = {cnt_q, pack_q, word_parity(pack_q)};
  assign {bus.word_len, bus.word_out, bus.word_parity} = fifo_dout;
`else
  assign fifo_din = {cnt_q, pack_q};
  assign {bus.word_len, bus.word_out} = fifo_dout;
`endif

  nibble_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.word_valid = !fifo_empty;
  assign bus.fifo_full  = fifo_full;

endmodule
